// File: rtl/dht11_scheduler.sv
// Periodic DHT11 measurement scheduler: triggers the sensor controller, retries on
// checksum failure or timeout, and keeps the last good reading as BCD.
module dht11_scheduler #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int PERIOD_MS    = 2000,
    parameter int TIMEOUT_MS   = 50,
    parameter int RETRY_GAP_MS = 1000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rh_data,
    input  logic [7:0] temp_data,
    input  logic       dht11_done,
    input  logic       dht11_valid,
    output logic       dht11_start,
    output logic [7:0] rh_bcd,
    output logic [7:0] temp_bcd,
    output logic       new_sample,
    output logic       data_ok,
    output logic       err_flag,
    output logic       busy
);

    localparam int PRESC_DIV = CLK_HZ / 1000;
    localparam int PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int MAX_MS    = (PERIOD_MS > TIMEOUT_MS)
                             ? ((PERIOD_MS > RETRY_GAP_MS) ? PERIOD_MS : RETRY_GAP_MS)
                             : ((TIMEOUT_MS > RETRY_GAP_MS) ? TIMEOUT_MS : RETRY_GAP_MS);
    localparam int MS_W      = $clog2(MAX_MS + 1);
    localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(PRESC_DIV - 1);
    localparam logic [MS_W-1:0]    PERIOD_LAST  = MS_W'(PERIOD_MS - 1);
    localparam logic [MS_W-1:0]    TIMEOUT_LAST = MS_W'(TIMEOUT_MS - 1);
    localparam logic [MS_W-1:0]    GAP_LAST     = MS_W'(RETRY_GAP_MS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_DONE,
        RETRY_GAP,
        HOLD
    } state_t;

    state_t             state, state_next;
    logic [PRESC_W-1:0] presc;
    logic [MS_W-1:0]    ms_cnt;
    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic               ms_tick;
    logic               latch_good;
    logic               set_err;
    logic               fail;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        if (v > 8'd99)
            return 8'h99;
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // A duration "is reached" on the tick that would make ms_cnt equal to it, so the
    // state change lands exactly N ms after entry.
    assign ms_tick = (presc == PRESC_LAST);
    assign busy    = (state == TRIG) || (state == WAIT_DONE);

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        latch_good = 1'b0;
        set_err    = 1'b0;
        fail       = 1'b0;

        case (state)
            IDLE: begin
                retry_next = '0;
                if (enable)
                    state_next = TRIG;
            end
            TRIG:
                state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (dht11_done && dht11_valid) begin
                    latch_good = 1'b1;
                    retry_next = '0;
                    state_next = HOLD;
                end else if (dht11_done || (ms_tick && ms_cnt == TIMEOUT_LAST)) begin
                    fail = 1'b1;
                end
            end
            RETRY_GAP:
                if (ms_tick && ms_cnt == GAP_LAST)
                    state_next = TRIG;
            HOLD:
                if (ms_tick && ms_cnt == PERIOD_LAST)
                    state_next = TRIG;
            default:
                state_next = IDLE;
        endcase

        if (fail) begin
            if (retry_cnt < RETRY_MAX) begin
                retry_next = retry_cnt + 1'b1;
                state_next = RETRY_GAP;
            end else begin
                set_err    = 1'b1;
                retry_next = '0;
                state_next = HOLD;
            end
        end

        // Disabling wins over everything, including a done pulse in the same cycle.
        if (!enable) begin
            state_next = IDLE;
            retry_next = '0;
            latch_good = 1'b0;
            set_err    = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            ms_cnt      <= '0;
            retry_cnt   <= '0;
            dht11_start <= 1'b0;
            rh_bcd      <= '0;
            temp_bcd    <= '0;
            new_sample  <= 1'b0;
            data_ok     <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_next;

            if (state_next != state) begin
                presc  <= '0;
                ms_cnt <= '0;
            end else if (ms_tick) begin
                presc  <= '0;
                ms_cnt <= ms_cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            dht11_start <= (state_next == TRIG);
            new_sample  <= latch_good;

            if (latch_good) begin
                rh_bcd   <= to_bcd(rh_data);
                temp_bcd <= to_bcd(temp_data);
                data_ok  <= 1'b1;
                err_flag <= 1'b0;
            end else if (set_err) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule
